// File: rtl/spatz_vfu_wb_buffer.sv
// rtl/spatz_vfu_wb_buffer.sv - VFU write-back buffer holding responses until their writes reach the VRF (option: SPATZ_VFU_WB_BYPASS_EN)
module spatz_vfu_wb_buffer #(
  parameter int unsigned Depth     = 2,
  parameter int unsigned RspDepth  = 2,
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned RspWidth  = 18
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [AddrWidth-1:0]   vfu_waddr_i,
  input  logic [DataWidth-1:0]   vfu_wdata_i,
  input  logic [DataWidth/8-1:0] vfu_wbe_i,
  input  logic                   vfu_we_i,
  output logic                   vfu_wvalid_o,
  input  logic                   vfu_rsp_valid_i,
  input  logic [RspWidth-1:0]    vfu_rsp_i,
  output logic [AddrWidth-1:0]   vrf_waddr_o,
  output logic [DataWidth-1:0]   vrf_wdata_o,
  output logic [DataWidth/8-1:0] vrf_wbe_o,
  output logic                   vrf_we_o,
  input  logic                   vrf_wvalid_i,
  output logic                   rsp_valid_o,
  output logic [RspWidth-1:0]    rsp_o,
  output logic                   overflow_o
);

  localparam int unsigned BeWidth     = DataWidth / 8;
  localparam int unsigned CntWidth    = $clog2(Depth) + 2;
  localparam int unsigned PtrWidth    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned FCntWidth   = $clog2(Depth + 1);
  localparam int unsigned RPtrWidth   = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam int unsigned RCntWidth   = $clog2(RspDepth + 1);

  logic [AddrWidth-1:0] waddr_q [Depth];
  logic [DataWidth-1:0] wdata_q [Depth];
  logic [BeWidth-1:0]   wbe_q   [Depth];
  logic [RspWidth-1:0]  rsp_q   [RspDepth];
  logic [CntWidth-1:0]  tgt_q   [RspDepth];

  logic [PtrWidth-1:0]  w_wptr_q, w_wptr_d, w_rptr_q, w_rptr_d;
  logic [FCntWidth-1:0] w_cnt_q, w_cnt_d;
  logic [RPtrWidth-1:0] r_wptr_q, r_wptr_d, r_rptr_q, r_rptr_d;
  logic [RCntWidth-1:0] r_cnt_q, r_cnt_d;
  logic [CntWidth-1:0]  wr_cnt_q, wr_cnt_d, ret_cnt_q, ret_cnt_d;
  logic                 overflow_q, overflow_d;

  logic                 w_empty, w_full, accept, push, pop, direct;
  logic                 r_empty, r_full, r_push, r_pop;
  logic [CntWidth-1:0]  target;

  assign w_empty = (w_cnt_q == '0);
  assign w_full  = (w_cnt_q == FCntWidth'(Depth));
  assign r_empty = (r_cnt_q == '0);
  assign r_full  = (r_cnt_q == RCntWidth'(RspDepth));

  // VRF-side view of the write path: queue head, or the live VFU write when bypassing an empty queue
  always_comb begin
`ifdef SPATZ_VFU_WB_BYPASS_EN
    vrf_we_o    = w_empty ? vfu_we_i    : 1'b1;
    vrf_waddr_o = w_empty ? vfu_waddr_i : waddr_q[w_rptr_q];
    vrf_wdata_o = w_empty ? vfu_wdata_i : wdata_q[w_rptr_q];
    vrf_wbe_o   = w_empty ? vfu_wbe_i   : wbe_q[w_rptr_q];
    direct      = w_empty && vfu_we_i && vrf_wvalid_i;
`else
    vrf_we_o    = !w_empty;
    vrf_waddr_o = w_empty ? '0 : waddr_q[w_rptr_q];
    vrf_wdata_o = w_empty ? '0 : wdata_q[w_rptr_q];
    vrf_wbe_o   = w_empty ? '0 : wbe_q[w_rptr_q];
    direct      = 1'b0;
`endif
  end

  // Handshakes, counters and response bookkeeping; release depends on registered state only
  always_comb begin
    accept     = vfu_we_i && !w_full;
    push       = accept && !direct;
    pop        = vrf_wvalid_i && !w_empty;
    r_pop      = !r_empty && (ret_cnt_q == tgt_q[r_rptr_q]);
    r_push     = vfu_rsp_valid_i && !r_full;
    target     = wr_cnt_q + CntWidth'(accept);
    w_wptr_d   = w_wptr_q;
    w_rptr_d   = w_rptr_q;
    r_wptr_d   = r_wptr_q;
    r_rptr_d   = r_rptr_q;
    if (push) w_wptr_d = (w_wptr_q == PtrWidth'(Depth - 1)) ? '0 : w_wptr_q + PtrWidth'(1);
    if (pop)  w_rptr_d = (w_rptr_q == PtrWidth'(Depth - 1)) ? '0 : w_rptr_q + PtrWidth'(1);
    if (r_push) r_wptr_d = (r_wptr_q == RPtrWidth'(RspDepth - 1)) ? '0 : r_wptr_q + RPtrWidth'(1);
    if (r_pop)  r_rptr_d = (r_rptr_q == RPtrWidth'(RspDepth - 1)) ? '0 : r_rptr_q + RPtrWidth'(1);
    w_cnt_d    = w_cnt_q + FCntWidth'(push) - FCntWidth'(pop);
    r_cnt_d    = r_cnt_q + RCntWidth'(r_push) - RCntWidth'(r_pop);
    wr_cnt_d   = wr_cnt_q + CntWidth'(accept);
    ret_cnt_d  = ret_cnt_q + CntWidth'(vrf_wvalid_i && vrf_we_o);
    overflow_d = overflow_q || (vfu_rsp_valid_i && r_full);
  end

  assign vfu_wvalid_o = accept;
  assign rsp_valid_o  = r_pop;
  assign rsp_o        = r_pop ? rsp_q[r_rptr_q] : '0;
  assign overflow_o   = overflow_q;

  // Control state; reset discards everything queued
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_wptr_q   <= '0;
      w_rptr_q   <= '0;
      w_cnt_q    <= '0;
      r_wptr_q   <= '0;
      r_rptr_q   <= '0;
      r_cnt_q    <= '0;
      wr_cnt_q   <= '0;
      ret_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      w_wptr_q   <= w_wptr_d;
      w_rptr_q   <= w_rptr_d;
      w_cnt_q    <= w_cnt_d;
      r_wptr_q   <= r_wptr_d;
      r_rptr_q   <= r_rptr_d;
      r_cnt_q    <= r_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      ret_cnt_q  <= ret_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload storage; contents are only observed behind valid counts, so no reset needed
  always_ff @(posedge clk_i) begin
    if (push) begin
      waddr_q[w_wptr_q] <= vfu_waddr_i;
      wdata_q[w_wptr_q] <= vfu_wdata_i;
      wbe_q[w_wptr_q]   <= vfu_wbe_i;
    end
    if (r_push) begin
      rsp_q[r_wptr_q] <= vfu_rsp_i;
      tgt_q[r_wptr_q] <= target;
    end
  end

`ifndef SYNTHESIS
  // Held VRF write must not change until the VRF takes it
  a_vrf_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (vrf_we_o && !vrf_wvalid_i) |=> ($stable(vrf_waddr_o) && $stable(vrf_wdata_o) && $stable(vrf_wbe_o)));
  // VRF may only acknowledge a write that is being offered
  a_vrf_ack : assert property (@(posedge clk_i) disable iff (rst_i) vrf_wvalid_i |-> vrf_we_o);
`endif

endmodule

// File: tb/tb_spatz_vfu_wb_buffer.sv
// tb/tb_spatz_vfu_wb_buffer.sv - self-checking bench for spatz_vfu_wb_buffer
module tb_spatz_vfu_wb_buffer;

  localparam int DEPTH = 2;
  localparam int RSPD  = 2;
`ifdef SPATZ_VFU_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  vfu_waddr;
  logic [63:0] vfu_wdata;
  logic [7:0]  vfu_wbe;
  logic        vfu_we, vfu_rsp_valid, vrf_ready;
  logic [17:0] vfu_rsp;
  logic        vfu_wvalid, vrf_we, rsp_valid, overflow;
  logic [7:0]  vrf_waddr;
  logic [63:0] vrf_wdata;
  logic [7:0]  vrf_wbe;
  logic [17:0] rsp;
  wire         vrf_wvalid = vrf_ready & vrf_we;

  always #5 clk = ~clk;

  spatz_vfu_wb_buffer #(.Depth(DEPTH), .RspDepth(RSPD), .AddrWidth(8), .DataWidth(64), .RspWidth(18)) dut (
    .clk_i(clk), .rst_i(rst),
    .vfu_waddr_i(vfu_waddr), .vfu_wdata_i(vfu_wdata), .vfu_wbe_i(vfu_wbe), .vfu_we_i(vfu_we),
    .vfu_wvalid_o(vfu_wvalid), .vfu_rsp_valid_i(vfu_rsp_valid), .vfu_rsp_i(vfu_rsp),
    .vrf_waddr_o(vrf_waddr), .vrf_wdata_o(vrf_wdata), .vrf_wbe_o(vrf_wbe), .vrf_we_o(vrf_we),
    .vrf_wvalid_i(vrf_wvalid), .rsp_valid_o(rsp_valid), .rsp_o(rsp), .overflow_o(overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] mk_rsp(input logic [2:0] id);
    return {id, 5'd1, 5'd2, 5'd3};
  endfunction

  // Reference model: queued writes, responses tagged with the number of writes that must retire first
  typedef struct packed { logic [7:0] a; logic [63:0] d; logic [7:0] be; } wr_t;
  typedef struct packed { logic [17:0] r; int tgt; } rs_t;
  wr_t wq[$];
  rs_t rq[$];
  int  n_acc, n_ret;
  bit  m_ovf;

  function automatic bit m_vrf_we();
    return (wq.size() > 0) || (BYP && vfu_we);
  endfunction
  function automatic bit m_accept();
    return vfu_we && (wq.size() < DEPTH);
  endfunction
  function automatic bit m_release();
    return (rq.size() > 0) && (rq[0].tgt == n_ret);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wq.delete(); rq.delete(); n_acc = 0; n_ret = 0; m_ovf = 0;
    end else begin
      automatic bit acc    = m_accept();
      automatic bit rel    = m_release();
      automatic bit ret    = vrf_ready && m_vrf_we();
      automatic bit direct = BYP && (wq.size() == 0) && vfu_we && vrf_ready;
      automatic int rsz    = rq.size();
      if (rel) void'(rq.pop_front());
      if (ret && wq.size() > 0) void'(wq.pop_front());
      if (acc && !direct) wq.push_back('{vfu_waddr, vfu_wdata, vfu_wbe});
      if (acc) n_acc++;
      if (ret) n_ret++;
      if (vfu_rsp_valid) begin
        if (rsz == RSPD) m_ovf = 1;
        else rq.push_back('{vfu_rsp, n_acc});
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("m_vfu_wvalid", vfu_wvalid, m_accept());
    chk("m_vrf_we", vrf_we, m_vrf_we());
    if (m_vrf_we()) begin
      if (wq.size() > 0) begin
        chk("m_vrf_waddr", vrf_waddr, wq[0].a);
        chk("m_vrf_wdata", vrf_wdata, wq[0].d);
        chk("m_vrf_wbe", vrf_wbe, wq[0].be);
      end else begin
        chk("m_byp_waddr", vrf_waddr, vfu_waddr);
        chk("m_byp_wdata", vrf_wdata, vfu_wdata);
      end
    end
    chk("m_rsp_valid", rsp_valid, m_release());
    if (m_release()) chk("m_rsp", rsp, rq[0].r);
    chk("m_overflow", overflow, m_ovf);
  end

  task automatic drive(input bit we, input logic [7:0] a, input bit rv, input logic [2:0] id, input bit rdy);
    vfu_we = we; vfu_waddr = a; vfu_wdata = {8{a}}; vfu_wbe = a ^ 8'hA5;
    vfu_rsp_valid = rv; vfu_rsp = mk_rsp(id); vrf_ready = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    drive(0, 8'h00, 0, 0, 0);
    @(negedge clk);
    chk("reset_vrf_we", vrf_we, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_vfu_wvalid", vfu_wvalid, 0);
    next_cycle();
    rst = 1'b0;

    // back-to-back writes with an always-ready VRF
    for (int k = 0; k < 5; k++) begin
      drive(k < 4, 8'h10 + 8'(k), 0, 0, 1);
      @(negedge clk);
      if (k < 4) chk("b2b_wvalid", vfu_wvalid, 1);
`ifdef SPATZ_VFU_WB_BYPASS_EN
      if (k < 4) begin
        chk("byp_same_cycle_we", vrf_we, 1);
        chk("byp_same_cycle_addr", vrf_waddr, 8'h10 + 8'(k));
      end
`else
      if (k >= 1) begin
        chk("b2b_we", vrf_we, 1);
        chk("b2b_addr", vrf_waddr, 8'h10 + 8'(k - 1));
      end
`endif
      next_cycle();
    end

    // stalled VRF fills the queue; third write refused until room frees
    for (int c = 0; c < 8; c++) begin
      drive(c < 7, (c == 0) ? 8'h20 : (c == 1) ? 8'h21 : 8'h22, 0, 0, c >= 5);
      @(negedge clk);
      case (c)
        2: chk("stall_third_refused", vfu_wvalid, 0);
        4: begin chk("stall_head_addr", vrf_waddr, 8'h20); chk("stall_head_data", vrf_wdata, {8{8'h20}}); end
        5: begin chk("stall_full_no_accept", vfu_wvalid, 0); chk("stall_pop0", vrf_waddr, 8'h20); end
        6: begin chk("stall_accept", vfu_wvalid, 1); chk("stall_pop1", vrf_waddr, 8'h21); end
        7: chk("stall_pop2", vrf_waddr, 8'h22);
        default: ;
      endcase
      next_cycle();
    end

    // last write of id 3 and its response in one cycle, VRF stalls 3 cycles
    for (int c = 0; c < 7; c++) begin
      drive(c < 2, (c == 0) ? 8'h30 : 8'h31, c == 1, 3'd3, c >= 3);
      @(negedge clk);
      case (c)
        4: begin chk("id3_final_addr", vrf_waddr, 8'h31); chk("id3_not_yet", rsp_valid, 0); end
        5: begin chk("id3_release", rsp_valid, 1); chk("id3_rsp", rsp, mk_rsp(3)); end
        6: chk("id3_single_pulse", rsp_valid, 0);
        default: ;
      endcase
      next_cycle();
    end

    // no-write response behind two queued writes, then with an empty queue
    for (int c = 0; c < 10; c++) begin
      drive(c < 2, (c == 0) ? 8'h40 : 8'h41, (c == 2) || (c == 7), 3'd5, c >= 3);
      @(negedge clk);
      case (c)
        3: chk("id5_wait0", rsp_valid, 0);
        4: chk("id5_wait1", rsp_valid, 0);
        5: begin chk("id5_release", rsp_valid, 1); chk("id5_rsp", rsp, mk_rsp(5)); end
        7: chk("id5_empty_capture", rsp_valid, 0);
        8: begin chk("id5_empty_next", rsp_valid, 1); chk("id5_empty_rsp", rsp, mk_rsp(5)); end
        default: ;
      endcase
      next_cycle();
    end

    // response FIFO overflow while stalled
    for (int c = 0; c < 9; c++) begin
      drive(c == 0, 8'h50, (c >= 1) && (c <= 3), 3'(c), c >= 5);
      @(negedge clk);
      case (c)
        3: chk("ovf_before", overflow, 0);
        4: chk("ovf_set", overflow, 1);
        6: begin chk("ovf_rel1", rsp_valid, 1); chk("ovf_rsp1", rsp, mk_rsp(1)); end
        7: begin chk("ovf_rel2", rsp_valid, 1); chk("ovf_rsp2", rsp, mk_rsp(2)); end
        8: begin chk("ovf_dropped", rsp_valid, 0); chk("ovf_sticky", overflow, 1); end
        default: ;
      endcase
      next_cycle();
    end

    // reset mid-stream with two queued writes and a pending response
    drive(1, 8'h60, 0, 0, 0); next_cycle();
    drive(1, 8'h61, 1, 3'd6, 0); next_cycle();
    drive(0, 8'h00, 0, 0, 0); rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_we", vrf_we, 0);
    chk("rst_mid_rsp", rsp_valid, 0);
    chk("rst_mid_ovf", overflow, 0);
    next_cycle();
    rst = 1'b0; drive(1, 8'h62, 0, 0, 0);
    @(negedge clk);
    chk("rst_after_wvalid", vfu_wvalid, 1);
    chk("rst_after_rsp", rsp_valid, 0);
`ifndef SPATZ_VFU_WB_BYPASS_EN
    chk("rst_after_we", vrf_we, 0);
`endif
    next_cycle();
    drive(0, 8'h00, 0, 0, 1);
    @(negedge clk);
    chk("rst_after_drain", vrf_waddr, 8'h62);
    next_cycle();

    // random writes and VRF readiness, checked by the model only
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), 8'h80 + 8'(i), 0, 0, 1'($urandom_range(0, 1)));
      next_cycle();
    end
    drive(0, 8'h00, 0, 0, 1);
    repeat (4) next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
